// File: rtl/dt_walker.sv
// dt_walker -- table-driven binary decision-tree classifier.
//
// Walks a run-time programmable node table one tree level per clock. A
// feature vector is accepted in IDLE, the tree is traversed from entry 0 in
// WALK, and the leaf value (or an error) is presented in DONE until taken.
//
// Ports:
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   cfg_we/addr/data      node-table write port (honoured only while IDLE)
//                         entry = {is_leaf, feat, hi, lo, leaf_val}
//   busy                  high whenever a vector is in flight or unacknowledged
//   in_valid/in_ready/inp feature-vector input handshake
//   out_valid/out_ready   result handshake
//   outp, out_err         leaf value (0 on error) and error flag
//   out_depth             internal nodes traversed, only when the optional
//                         macro DT_WALKER_DEPTH_OUT_EN is defined
`timescale 1ns/1ps
module dt_walker #(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 7,
   parameter int NODES     = 128,
   parameter int MAX_DEPTH = 16,
   localparam int AW = (NODES > 1) ? $clog2(NODES) : 1,
   localparam int FW = (IN_W > 1) ? $clog2(IN_W) : 1,
   localparam int EW = 1 + FW + 2 * AW + OUT_W,
   localparam int SW = $clog2(MAX_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [EW-1:0]    cfg_data,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  inp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] outp,
   output logic             out_err
`ifdef DT_WALKER_DEPTH_OUT_EN
   ,
   output logic [SW-1:0]    out_depth
`endif
);

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   // Cleared table entry: a leaf returning 0.
   localparam logic [EW-1:0] RST_ENT = {1'b1, {(EW-1){1'b0}}};

   state_t            state_q, state_d;
   logic [EW-1:0]     tbl_q [NODES];
   logic [EW-1:0]     tbl_d [NODES];
   logic [IN_W-1:0]   vec_q, vec_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [SW-1:0]     steps_q, steps_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  outp_q, outp_d;
   logic              out_err_q, out_err_d;
`ifdef DT_WALKER_DEPTH_OUT_EN
   logic [SW-1:0]     depth_q, depth_d;
`endif

   // Current node fields (asynchronous table read).
   logic [EW-1:0]     ent;
   logic              e_leaf;
   logic [FW-1:0]     e_feat;
   logic [AW-1:0]     e_hi, e_lo, nxt;
   logic [OUT_W-1:0]  e_val;
   logic              nxt_oob, feat_oob;

   assign ent    = tbl_q[ptr_q];
   assign e_leaf = ent[EW-1];
   assign e_feat = ent[OUT_W+2*AW +: FW];
   assign e_hi   = ent[OUT_W+AW +: AW];
   assign e_lo   = ent[OUT_W +: AW];
   assign e_val  = ent[OUT_W-1:0];
   assign nxt    = vec_q[e_feat] ? e_hi : e_lo;

   // Range checks only exist when the field can encode out-of-range values.
   generate
      if ((1 << AW) == NODES) begin : g_nodes_full
         assign nxt_oob = 1'b0;
      end else begin : g_nodes_part
         assign nxt_oob = (nxt > AW'(NODES - 1));
      end
      if ((1 << FW) == IN_W) begin : g_feat_full
         assign feat_oob = 1'b0;
      end else begin : g_feat_part
         assign feat_oob = (e_feat > FW'(IN_W - 1));
      end
   endgenerate

   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign outp      = outp_q;
   assign out_err   = out_err_q;
`ifdef DT_WALKER_DEPTH_OUT_EN
   assign out_depth = depth_q;
`endif

   always_comb begin
      state_d     = state_q;
      tbl_d       = tbl_q;
      vec_d       = vec_q;
      ptr_d       = ptr_q;
      steps_d     = steps_q;
      out_valid_d = out_valid_q;
      outp_d      = outp_q;
      out_err_d   = out_err_q;
`ifdef DT_WALKER_DEPTH_OUT_EN
      depth_d     = depth_q;
`endif

      // Writes in IDLE land on the accept edge too, so a walk starting on
      // that edge already sees the new entry. Addresses >= NODES match no row.
      if (cfg_we && (state_q == IDLE)) begin
         for (int i = 0; i < NODES; i++) begin
            if (cfg_addr == AW'(i)) tbl_d[i] = cfg_data;
         end
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               vec_d   = inp;
               ptr_d   = '0;
               steps_d = '0;
               state_d = WALK;
            end
         end
         WALK: begin
            if (e_leaf) begin
               outp_d      = e_val;
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = DONE;
`ifdef DT_WALKER_DEPTH_OUT_EN
               depth_d     = steps_q;
`endif
            end else if ((steps_q == SW'(MAX_DEPTH)) || nxt_oob || feat_oob) begin
               outp_d      = '0;
               out_err_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = DONE;
`ifdef DT_WALKER_DEPTH_OUT_EN
               depth_d     = steps_q;
`endif
            end else begin
               ptr_d   = nxt;
               steps_d = steps_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         steps_q     <= '0;
         out_valid_q <= 1'b0;
         outp_q      <= '0;
         out_err_q   <= 1'b0;
`ifdef DT_WALKER_DEPTH_OUT_EN
         depth_q     <= '0;
`endif
         for (int i = 0; i < NODES; i++) tbl_q[i] <= RST_ENT;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         steps_q     <= steps_d;
         out_valid_q <= out_valid_d;
         outp_q      <= outp_d;
         out_err_q   <= out_err_d;
`ifdef DT_WALKER_DEPTH_OUT_EN
         depth_q     <= depth_d;
`endif
         tbl_q       <= tbl_d;
      end
   end

   // Feature vector is pure data and only meaningful after an accept.
   always_ff @(posedge clk) begin
      vec_q <= vec_d;
   end

endmodule

// File: tb/tb_dt_walker.sv
// tb_dt_walker -- self-checking bench for dt_walker.
// Two instances share clock, reset, config and feature inputs: dut_a uses a
// 16-entry table, dut_b a 12-entry table for the out-of-range child case.
`timescale 1ns/1ps
module tb_dt_walker;

   localparam int IN_W      = 8;
   localparam int OUT_W     = 7;
   localparam int NODES     = 16;
   localparam int NODES_B   = 12;
   localparam int MAX_DEPTH = 4;
   localparam int AW        = 4;
   localparam int FW        = 3;
   localparam int EW        = 1 + FW + 2 * AW + OUT_W;
   localparam int SW        = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_we = 1'b0;
   logic [AW-1:0]    cfg_addr = '0;
   logic [EW-1:0]    cfg_data = '0;
   logic [IN_W-1:0]  inp = '0;
   logic             a_in_valid = 1'b0, b_in_valid = 1'b0;
   logic             a_out_ready = 1'b1, b_out_ready = 1'b1;
   logic             a_busy, b_busy, a_in_ready, b_in_ready;
   logic             a_out_valid, b_out_valid, a_out_err, b_out_err;
   logic [OUT_W-1:0] a_outp, b_outp;
`ifdef DT_WALKER_DEPTH_OUT_EN
   logic [SW-1:0]    a_out_depth, b_out_depth;
`endif

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   dt_walker #(.IN_W(IN_W), .OUT_W(OUT_W), .NODES(NODES), .MAX_DEPTH(MAX_DEPTH)) dut_a (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .busy(a_busy), .in_valid(a_in_valid), .in_ready(a_in_ready), .inp(inp),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .outp(a_outp), .out_err(a_out_err)
`ifdef DT_WALKER_DEPTH_OUT_EN
      , .out_depth(a_out_depth)
`endif
   );

   dt_walker #(.IN_W(IN_W), .OUT_W(OUT_W), .NODES(NODES_B), .MAX_DEPTH(MAX_DEPTH)) dut_b (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .busy(b_busy), .in_valid(b_in_valid), .in_ready(b_in_ready), .inp(inp),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .outp(b_outp), .out_err(b_out_err)
`ifdef DT_WALKER_DEPTH_OUT_EN
      , .out_depth(b_out_depth)
`endif
   );

   // Reference tree, as the bench believes it is programmed.
   typedef struct {
      bit leaf;
      int feat;
      int hi;
      int lo;
      int val;
   } node_t;
   node_t mtab [NODES];

   task automatic model_reset();
      for (int i = 0; i < NODES; i++) mtab[i] = '{leaf: 1'b1, feat: 0, hi: 0, lo: 0, val: 0};
   endtask

   // Follow the tree rules directly: leaf -> value; depth budget exhausted or
   // bad child/feature -> error. Latency is one cycle per node visited.
   function automatic void ref_walk(input logic [IN_W-1:0] v, input int nodes,
                                    output int res, output int err,
                                    output int depth, output int lat);
      int p = 0;
      int s = 0;
      int nx;
      res = 0; err = 0; depth = 0; lat = 0;
      for (int guard = 0; guard <= MAX_DEPTH; guard++) begin
         if (mtab[p].leaf) begin
            res = mtab[p].val; err = 0; depth = s; lat = s + 1;
            return;
         end
         if (s == MAX_DEPTH) begin
            res = 0; err = 1; depth = s; lat = s + 1;
            return;
         end
         nx = v[mtab[p].feat] ? mtab[p].hi : mtab[p].lo;
         if (nx >= nodes || mtab[p].feat >= IN_W) begin
            res = 0; err = 1; depth = s; lat = s + 1;
            return;
         end
         p = nx;
         s++;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [AW-1:0] addr, input logic leaf,
                            input logic [FW-1:0] feat, input logic [AW-1:0] hi,
                            input logic [AW-1:0] lo, input logic [OUT_W-1:0] val,
                            input bit upd);
      cfg_addr = addr;
      cfg_data = {leaf, feat, hi, lo, val};
      cfg_we   = 1'b1;
      tick();
      cfg_we   = 1'b0;
      if (upd) mtab[addr] = '{leaf: leaf, feat: int'(feat), hi: int'(hi), lo: int'(lo), val: int'(val)};
   endtask

   // Present one vector to the selected instance and wait (bounded) for its result.
   task automatic send(input string tag, input int sel, input logic [IN_W-1:0] v,
                       output int lat, output int res, output int err, output int dep);
      logic ov;
      chk({tag, "_in_ready"}, sel ? b_in_ready : a_in_ready, 1);
      inp = v;
      if (sel == 0) a_in_valid = 1'b1; else b_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      chk({tag, "_busy"}, sel ? b_busy : a_busy, 1);
      lat = 0;
      do begin
         tick();
         lat++;
         ov = sel ? b_out_valid : a_out_valid;
      end while (!ov && lat < 40);
      if (!ov) chk({tag, "_timeout"}, 0, 1);
      res = int'(sel ? b_outp : a_outp);
      err = int'(sel ? b_out_err : a_out_err);
`ifdef DT_WALKER_DEPTH_OUT_EN
      dep = int'(sel ? b_out_depth : a_out_depth);
`else
      dep = -1;
`endif
      if ((sel ? b_out_ready : a_out_ready) == 1'b1) tick();
   endtask

   task automatic check_vec(input string tag, input int sel, input logic [IN_W-1:0] v,
                            input int er, input int ee, input int el, input int ed);
      int lat, res, err, dep;
      send(tag, sel, v, lat, res, err, dep);
      chk({tag, "_outp"}, res, er);
      chk({tag, "_err"}, err, ee);
      chk({tag, "_lat"}, lat, el);
`ifdef DT_WALKER_DEPTH_OUT_EN
      chk({tag, "_depth"}, dep, ed);
`else
      if (ed < 0) chk({tag, "_depth_arg"}, 0, 1);
`endif
   endtask

   task automatic check_model(input string tag, input int sel, input logic [IN_W-1:0] v);
      int res, err, dep, lat;
      ref_walk(v, sel ? NODES_B : NODES, res, err, dep, lat);
      check_vec(tag, sel, v, res, err, lat, dep);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_outp", a_outp, 0);
      chk("rst_out_err", a_out_err, 0);
      chk("rst_busy", a_busy, 0);
`ifdef DT_WALKER_DEPTH_OUT_EN
      chk("rst_depth", a_out_depth, 0);
`endif

      // Cleared table: root leaf returns 0 after one cycle
      check_vec("empty_a5", 0, 8'hA5, 0, 0, 1, 0);

      // Load the reference tree
      cfg_write(0, 1'b0, 3'd5, 4'd2, 4'd1, 7'h00, 1'b1);
      cfg_write(1, 1'b1, 3'd0, 4'd0, 4'd0, 7'h35, 1'b1);
      cfg_write(2, 1'b0, 3'd2, 4'd4, 4'd3, 7'h00, 1'b1);
      cfg_write(3, 1'b1, 3'd0, 4'd0, 4'd0, 7'h05, 1'b1);
      cfg_write(4, 1'b1, 3'd0, 4'd0, 4'd0, 7'h21, 1'b1);
      check_vec("tree_00", 0, 8'h00, 7'h35, 0, 2, 1);
      check_vec("tree_20", 0, 8'h20, 7'h05, 0, 3, 2);
      check_vec("tree_24", 0, 8'h24, 7'h21, 0, 3, 2);

      // Self-loop exhausts the depth budget
      cfg_write(0, 1'b0, 3'd0, 4'd0, 4'd0, 7'h00, 1'b1);
      check_vec("selfloop", 0, 8'h5A, 0, 1, MAX_DEPTH + 1, MAX_DEPTH);

      // Child 13 is out of range for the 12-entry table but valid for 16
      cfg_write(0, 1'b0, 3'd0, 4'd13, 4'd13, 7'h00, 1'b1);
      check_vec("oob_b", 1, 8'h00, 0, 1, 1, 0);
      chk("oob_b_idle", b_busy, 0);
      check_vec("inrange_a", 0, 8'h00, 0, 0, 2, 1);

      // Backpressure with an ignored table write during the hold
      cfg_write(0, 1'b0, 3'd5, 4'd2, 4'd1, 7'h00, 1'b1);
      a_out_ready = 1'b0;
      check_vec("bp_first", 0, 8'h00, 7'h35, 0, 2, 1);
      cfg_write(1, 1'b1, 3'd0, 4'd0, 4'd0, 7'h7F, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_outp", a_outp, 7'h35);
         chk("bp_hold_valid", a_out_valid, 1);
         chk("bp_hold_in_ready", a_in_ready, 0);
         tick();
      end
      a_out_ready = 1'b1;
      chk("bp_release_in_ready", a_in_ready, 0);
      tick();
      chk("bp_after_valid", a_out_valid, 0);
      chk("bp_after_in_ready", a_in_ready, 1);
      check_vec("bp_reread", 0, 8'h00, 7'h35, 0, 2, 1);

      // Random trees against the reference model
      for (int r = 0; r < 3; r++) begin
         for (int n = 0; n < NODES; n++) begin
            cfg_write(AW'(n), ($urandom_range(0, 2) == 0), FW'($urandom_range(0, 7)),
                      AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                      OUT_W'($urandom_range(0, 127)), 1'b1);
         end
         for (int k = 0; k < 12; k++) check_model("rand", 0, IN_W'($urandom));
      end

      // Reset in the middle of a walk
      cfg_write(0, 1'b0, 3'd0, 4'd0, 4'd0, 7'h00, 1'b1);
      inp = IN_W'($urandom);
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("midrst_busy", a_busy, 0);
      chk("midrst_in_ready", a_in_ready, 1);
      seen = a_out_valid;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | a_out_valid;
      end
      chk("midrst_no_valid", seen, 0);
      check_vec("midrst_cleared", 0, 8'hA5, 0, 0, 1, 0);
      check_model("midrst_rand", 0, IN_W'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
